// File: rtl/silent_convergence_monitor.sv
// Scans all transducer channels once per START period and flags when filtered duty/phase words reach their targets.
// Optional timeout: define SILENT_MON_TIMEOUT_EN to enable the FAIL state after TIMEOUT_PERIODS mismatching scans.
module silent_convergence_monitor #(
  parameter int WIDTH           = 13,
  parameter int DEPTH           = 249,
  parameter int TIMEOUT_PERIODS = 255
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             START,
  input  logic                             ARM,
  output logic [$clog2(DEPTH)-1:0]         ADDR,
  input  logic signed [WIDTH-1:0]          TGT_DUTY,
  input  logic signed [WIDTH-1:0]          TGT_PHASE,
  input  logic signed [WIDTH-1:0]          DUTY_S,
  input  logic signed [WIDTH-1:0]          PHASE_S,
  output logic                             BUSY,
  output logic                             CONVERGED,
  output logic                             TIMEOUT,
  output logic [7:0]                       PERIOD_CNT,
  output logic [$clog2(DEPTH+1)-1:0]       MISMATCH_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

`ifdef SILENT_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE, S_FAIL} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state;
  logic            start_d;
  logic            busy_q;
  logic            conv_q;
  logic            to_q;
  logic [7:0]      pcnt_q;
  logic [CW-1:0]   mcnt_q;
  logic [CW-1:0]   scan_cnt;
  logic [AW-1:0]   addr_p0;
  logic            vld_p1;
  logic [CW-1:0]   acc_p1;

  logic            start_edge;
  logic            mm_p1;
  logic [CW-1:0]   acc_base;
  logic [CW-1:0]   scan_total;
  logic            scan_last;
  logic [7:0]      pcnt_inc;

  assign start_edge = START & ~start_d;
  assign scan_last  = (scan_cnt == CW'(DEPTH));
  assign pcnt_inc   = sat_inc8(pcnt_q);

  // Stage p1: memory words for the previous ADDR are compared and accumulated
  assign mm_p1      = vld_p1 & ((DUTY_S != TGT_DUTY) | (PHASE_S != TGT_PHASE));
  assign acc_base   = (scan_cnt == CW'(1)) ? '0 : acc_p1;
  assign scan_total = acc_base + CW'(mm_p1);

  always_ff @(posedge CLK) begin
    if (vld_p1) acc_p1 <= scan_total;
  end

  // Stage p0: control FSM issues ADDR and decides at the end of each scan
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      start_d  <= 1'b0;
      busy_q   <= 1'b0;
      conv_q   <= 1'b0;
      to_q     <= 1'b0;
      pcnt_q   <= '0;
      mcnt_q   <= '0;
      scan_cnt <= '0;
      addr_p0  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      start_d <= START;
      vld_p1  <= (state == S_SCAN) && (scan_cnt < CW'(DEPTH)) && !ARM;
      addr_p0 <= '0;
      if (ARM) begin
        state    <= S_WAIT;
        busy_q   <= 1'b1;
        conv_q   <= 1'b0;
        to_q     <= 1'b0;
        pcnt_q   <= '0;
        mcnt_q   <= '0;
        scan_cnt <= '0;
      end else begin
        case (state)
          S_WAIT: begin
            if (start_edge) begin
              state    <= S_SCAN;
              scan_cnt <= '0;
            end
          end
          S_SCAN: begin
            if (scan_last) begin
              mcnt_q   <= scan_total;
              scan_cnt <= '0;
              if (scan_total == '0) begin
                state  <= S_DONE;
                conv_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                pcnt_q <= pcnt_inc;
                if (TO_EN && (pcnt_inc == 8'(TIMEOUT_PERIODS))) begin
                  state  <= S_FAIL;
                  to_q   <= 1'b1;
                  busy_q <= 1'b0;
                end else begin
                  state <= S_WAIT;
                end
              end
            end else begin
              scan_cnt <= scan_cnt + CW'(1);
              addr_p0  <= (scan_cnt < CW'(DEPTH-1)) ? addr_p0 + AW'(1) : '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ADDR         = addr_p0;
  assign BUSY         = busy_q;
  assign CONVERGED    = conv_q;
  assign TIMEOUT      = TO_EN ? to_q : 1'b0;
  assign PERIOD_CNT   = pcnt_q;
  assign MISMATCH_CNT = mcnt_q;

endmodule
